// File: rtl/bin2bcd_pkg.sv
// Shared types, constants and the per-nibble add-3 correction for the
// sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, CONV = 1'b1} b2b_state_t;

    localparam int BCD_NIB = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    function automatic logic [3:0] add3_adj(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_dabble_step.sv
// One double-dabble iteration: correct every BCD nibble that would overflow
// when doubled, then shift the whole working register left by one bit.
module bcd_dabble_step
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic [DIGITS*BCD_NIB+BIN_W-1:0] sh_i,
    output logic [DIGITS*BCD_NIB+BIN_W-1:0] sh_o
);

    localparam int SH_W = DIGITS*BCD_NIB + BIN_W;

    logic [SH_W-1:0] adj_s;

    // Add-3 correction on the BCD field only; the binary field passes through.
    always_comb begin
        adj_s = sh_i;
        for (int d = 0; d < DIGITS; d++) begin
            adj_s[BIN_W + d*BCD_NIB +: BCD_NIB] = add3_adj(sh_i[BIN_W + d*BCD_NIB +: BCD_NIB]);
        end
    end

    // The dropped MSB is always zero because the digit count covers the input range.
    always_comb begin
        sh_o = adj_s << 1;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with a
// start/busy/done handshake and a held output register.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [BIN_W-1:0]            bin,
    output logic                        busy,
    output logic                        done,
    output logic [DIGITS*BCD_NIB-1:0]   bcd
);

    localparam int BCD_W = DIGITS*BCD_NIB;
    localparam int SH_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    if (!(10**DIGITS > 2**BIN_W - 1)) begin : g_digits_chk
        $error("bin2bcd_seq: DIGITS too small to represent 2**BIN_W-1");
    end

    logic [0:0]       state_q, state_d;
    logic [SH_W-1:0]  sh_q,    sh_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [BCD_W-1:0] bcd_q,   bcd_d;
    logic [SH_W-1:0]  step_s;

    bcd_dabble_step #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_step (
        .sh_i (sh_q),
        .sh_o (step_s)
    );

    // Next-state logic: accept in IDLE, iterate in CONV, publish on the last bit.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d    = {{BCD_W{1'b0}}, bin};
                    cnt_d   = CNT_W'(BIN_W);
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                sh_d  = step_s;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = step_s[SH_W-1 -: BCD_W];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            sh_q    <= {SH_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= {BCD_W{1'b0}};
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: the driver pushes decimal expectations,
// an independent monitor pops and compares on every done pulse.
module tb_bin2bcd_seq;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        start  = 1'b0;
    logic [15:0] bin    = 16'd0;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          passed   = 0;
    int          done_cnt = 0;
    longint      cyc      = 0;
    logic [19:0] exp_q[$];
    longint      acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by plain division.
    function automatic logic [19:0] dec_model(input int unsigned v);
        logic [19:0] r;
        int unsigned p;
        r = 20'd0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pop, latency, busy length, pulse shape and output hold.
    logic [19:0] prev_bcd  = 20'd0;
    logic        prev_done = 1'b0;
    int          busy_run  = 0;
    always @(negedge clk) begin
        if (!resetn) begin
            prev_bcd  = bcd;
            prev_done = 1'b0;
            busy_run  = 0;
        end else begin
            if (done) begin
                done_cnt++;
                chk("done_busy_exclusive", busy, 0);
                chk("done_single_cycle", prev_done, 0);
                chk("busy_len", busy_run, 16);
                busy_run = 0;
                for (int i = 0; i < 5; i++) chk("nibble_le9", (bcd[4*i +: 4] <= 4'd9), 1);
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    chk("bcd", bcd, exp_q.pop_front());
                    // accept edge k to done sampled after edge k+16
                    chk("latency", cyc - acc_q.pop_front(), 16);
                end
            end else begin
                chk("bcd_hold", bcd, prev_bcd);
            end
            if (busy) busy_run++;
            prev_bcd  = bcd;
            prev_done = done;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Called just after a negedge while the converter is idle.
    task automatic issue(input logic [15:0] v);
        start = 1'b1;
        bin   = v;
        exp_q.push_back(dec_model(v));
        acc_q.push_back(cyc + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        bin   = 16'($urandom);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_timeout", ok, 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int d0;
        logic [15:0] v;
        logic [15:0] t2 [3];
        t2[0] = 16'd0; t2[1] = 16'h270F; t2[2] = 16'h0100;

        idle(2);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 0);
        resetn = 1'b1;
        idle(2);

        issue(16'hFFFF);
        wait_done();
        chk("bcd_65535", bcd, 20'h65535);
        idle(2);

        foreach (t2[i]) begin
            issue(t2[i]);
            wait_done();
            idle(1);
        end

        issue(16'd255);
        idle(4);
        start = 1'b1;
        bin   = 16'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        chk("bcd_255", bcd, 20'h00255);
        d0 = done_cnt;
        idle(20);
        chk("ignored_start_one_done", done_cnt, d0);

        issue(16'd225);
        wait_done();
        chk("bcd_225", bcd, 20'h00225);
        issue(16'd100);
        wait_done();
        chk("bcd_100", bcd, 20'h00100);
        idle(2);

        issue(16'hFFFF);
        wait_done();
        idle(1);
        issue(16'd42);
        idle(5);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_bcd", bcd, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        exp_q.delete();
        acc_q.delete();
        idle(3);
        resetn = 1'b1;
        d0 = done_cnt;
        idle(30);
        chk("no_done_after_reset", done_cnt, d0);

        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 19) == 0) v = 16'hFFFF;
            else if ($urandom_range(0, 19) == 0) v = 16'd0;
            else v = 16'($urandom);
            issue(v);
            wait_done();
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(2);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
